// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: per-lane receive deserializer.
// Hunts bit-by-bit for the COM symbol, confirms byte alignment after a run
// of consecutive aligned COMs, then emits one byte per 8 bit clocks with a
// valid flag that is low for COM (idle) bytes.
// Optional build macro RX_BYTE_COUNT_EN adds a saturating 16-bit count of
// received data bytes on port rx_byte_count.
module serial_paralelo_rx #(
    parameter logic [7:0]  COM       = 8'hBC,
    parameter int unsigned COM_COUNT = 4
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        data_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        byte_strobe,
    output logic        active
`ifdef RX_BYTE_COUNT_EN
    ,
    output logic [15:0] rx_byte_count
`endif
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_ALIGN  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    // Lock threshold narrowed to the width of the COM run counter.
    localparam logic [3:0] COM_LOCK = 4'(COM_COUNT);

    logic [1:0] state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic       valid_q, valid_d;
    logic       strobe_q, strobe_d;
    logic       active_q, active_d;

    logic [7:0] nxt;
    logic       boundary;
    logic       nxt_is_com;

    assign nxt        = {sr_q[6:0], data_in};
    assign boundary   = (bit_cnt_q == 3'd7);
    assign nxt_is_com = (nxt == COM);

    // Next-state logic: hunt for COM, count aligned COMs, then deliver bytes.
    always_comb begin
        state_d    = state_q;
        sr_d       = nxt;
        bit_cnt_d  = bit_cnt_q;
        com_cnt_d  = com_cnt_q;
        data_out_d = data_out_q;
        valid_d    = valid_q;
        strobe_d   = 1'b0;
        active_d   = active_q;

        case (state_q)
            ST_SEARCH: begin
                if (nxt_is_com) begin
                    bit_cnt_d = 3'd0;
                    com_cnt_d = 4'd1;
                    state_d   = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    if (nxt_is_com) begin
                        if (com_cnt_q + 4'd1 == COM_LOCK) begin
                            state_d  = ST_ACTIVE;
                            active_d = 1'b1;
                        end else begin
                            com_cnt_d = com_cnt_q + 4'd1;
                        end
                    end else begin
                        // The rejected byte is not re-examined; the hunt
                        // restarts with the next incoming bit.
                        state_d   = ST_SEARCH;
                        com_cnt_d = 4'd0;
                    end
                end
            end
            ST_ACTIVE: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    data_out_d = nxt;
                    valid_d    = !nxt_is_com;
                    strobe_d   = 1'b1;
                end
            end
            default: begin
                state_d   = ST_SEARCH;
                bit_cnt_d = 3'd0;
                com_cnt_d = 4'd0;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q    <= ST_SEARCH;
            sr_q       <= 8'h00;
            bit_cnt_q  <= 3'd0;
            com_cnt_q  <= 4'd0;
            data_out_q <= 8'h00;
            valid_q    <= 1'b0;
            strobe_q   <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            com_cnt_q  <= com_cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            strobe_q   <= strobe_d;
            active_q   <= active_d;
        end
    end

    assign data_out    = data_out_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

`ifdef RX_BYTE_COUNT_EN
    logic [15:0] byte_count_q, byte_count_d;

    // Count data (non-COM) bytes delivered while locked, holding at all-ones.
    always_comb begin
        byte_count_d = byte_count_q;
        if (state_q == ST_ACTIVE && boundary && !nxt_is_com &&
            byte_count_q != 16'hFFFF) begin
            byte_count_d = byte_count_q + 16'd1;
        end
    end

    // Byte counter register, cleared by reset.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            byte_count_q <= 16'h0000;
        end else begin
            byte_count_q <= byte_count_d;
        end
    end

    assign rx_byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// tb_serial_paralelo_rx: self-checking bench for serial_paralelo_rx.
// The reference model keeps every bit received since the last reset and
// derives lock point and byte boundaries from that whole history.
module tb_serial_paralelo_rx;

    localparam logic [7:0] COM       = 8'hBC;
    localparam int         COM_COUNT = 4;

    logic        clk_32f = 1'b0;
    logic        reset   = 1'b1;
    logic        data_in = 1'b0;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        byte_strobe;
    logic        active;
`ifdef RX_BYTE_COUNT_EN
    logic [15:0] rx_byte_count;
`endif

    int checks = 0;
    int errors = 0;
    bit bits_q[$];

    serial_paralelo_rx #(
        .COM       (COM),
        .COM_COUNT (COM_COUNT)
    ) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
`ifdef RX_BYTE_COUNT_EN
        ,
        .rx_byte_count (rx_byte_count)
`endif
    );

    // Bit clock.
    always #5 clk_32f = ~clk_32f;

    // Compare one observed value with its expected value.
    task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // The 8 most recent bits ending at index i (bits before reset read as 0).
    function automatic logic [7:0] window_at(input int i);
        logic [7:0] w;
        int j;
        w = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            j = i - k;
            w = {w[6:0], (j >= 0 && j < bits_q.size()) ? bits_q[j] : 1'b0};
        end
        return w;
    endfunction

    // Edge index at which lock is declared, or -1 if not locked yet.
    function automatic int find_lock();
        int n;
        int pos;
        int i;
        int e;
        bit ok;
        n   = bits_q.size();
        pos = 0;
        while (1) begin
            i = pos;
            while (i < n && window_at(i) != COM) i++;
            if (i >= n) return -1;
            ok = 1'b1;
            for (int k = 1; k < COM_COUNT; k++) begin
                e = i + 8 * k;
                if (e >= n) return -1;
                if (window_at(e) != COM) begin
                    pos = e + 1;
                    ok  = 1'b0;
                    break;
                end
            end
            if (ok) return i + 8 * (COM_COUNT - 1);
        end
        return -1;
    endfunction

    // Compare every output against the model after the latest edge.
    task automatic check_model();
        int e;
        int lock;
        int last_b;
        logic       exp_active;
        logic       exp_strobe;
        logic [7:0] exp_data;
        logic       exp_valid;
        e          = bits_q.size() - 1;
        lock       = find_lock();
        exp_active = (lock >= 0);
        exp_strobe = (lock >= 0) && (e > lock) && ((e - lock) % 8 == 0);
        exp_data   = 8'h00;
        exp_valid  = 1'b0;
        if (lock >= 0 && e >= lock + 8) begin
            last_b    = lock + 8 * ((e - lock) / 8);
            exp_data  = window_at(last_b);
            exp_valid = (exp_data != COM);
        end
        check_output("active", 16'(active), 16'(exp_active));
        check_output("byte_strobe", 16'(byte_strobe), 16'(exp_strobe));
        check_output("data_out", 16'(data_out), 16'(exp_data));
        check_output("valid_out", 16'(valid_out), 16'(exp_valid));
`ifdef RX_BYTE_COUNT_EN
        begin
            int cnt;
            cnt = 0;
            if (lock >= 0) begin
                for (int b = lock + 8; b <= e; b += 8) begin
                    if (window_at(b) != COM && cnt < 65535) cnt++;
                end
            end
            check_output("rx_byte_count", rx_byte_count, 16'(cnt));
        end
`endif
    endtask

    // Drive one serial bit, clock it in, then check at the falling edge.
    task automatic send_bit(input bit b);
        data_in = b;
        @(posedge clk_32f);
        bits_q.push_back(b);
        @(negedge clk_32f);
        check_model();
    endtask

    // Serialize a byte, MSB first.
    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    // Hold reset for a number of clocks, check cleared outputs, release.
    task automatic apply_reset(input int cycles);
        @(negedge clk_32f);
        reset   = 1'b1;
        data_in = 1'b1;
        repeat (cycles) @(posedge clk_32f);
        @(negedge clk_32f);
        check_output("rst_data_out", 16'(data_out), 16'h0000);
        check_output("rst_valid", 16'(valid_out), 16'h0000);
        check_output("rst_strobe", 16'(byte_strobe), 16'h0000);
        check_output("rst_active", 16'(active), 16'h0000);
        reset = 1'b0;
        bits_q.delete();
    endtask

    // Directed scenarios followed by randomized streams.
    initial begin
        logic [7:0] rb;

        $display("[TB] start");

        // Reset with data_in high, then a long run of zeros.
        apply_reset(5);
        repeat (40) send_bit(1'b0);
        check_output("t1_search", 16'(active), 16'h0000);

        // Junk bits, lock on the 4th COM, then two data bytes.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        repeat (3) send_byte(COM);
        check_output("t2_not_yet", 16'(active), 16'h0000);
        send_byte(COM);
        check_output("t2_lock", 16'(active), 16'h0001);
        check_output("t2_no_strobe", 16'(byte_strobe), 16'h0000);
        send_byte(8'hA5);
        check_output("t2_a5_strobe", 16'(byte_strobe), 16'h0001);
        check_output("t2_a5_data", 16'(data_out), 16'h00A5);
        check_output("t2_a5_valid", 16'(valid_out), 16'h0001);
        send_byte(8'h3C);
        check_output("t2_3c_data", 16'(data_out), 16'h003C);

        // Idle and data mixed while locked.
        send_byte(COM);
        check_output("t3_bc_data", 16'(data_out), 16'h00BC);
        check_output("t3_bc_valid", 16'(valid_out), 16'h0000);
        send_byte(8'h5A);
        check_output("t3_5a_data", 16'(data_out), 16'h005A);
        check_output("t3_5a_valid", 16'(valid_out), 16'h0001);
        send_byte(COM);
        check_output("t3_bc2_valid", 16'(valid_out), 16'h0000);

        // Broken COM run, then a good one.
        apply_reset(2);
        repeat (3) send_byte(COM);
        send_byte(8'h00);
        check_output("t4_broken", 16'(active), 16'h0000);
        repeat (4) send_byte(COM);
        check_output("t4_lock", 16'(active), 16'h0001);
        send_byte(8'h11);
        check_output("t4_11_data", 16'(data_out), 16'h0011);
        check_output("t4_11_valid", 16'(valid_out), 16'h0001);

        // Asynchronous reset mid-byte while locked.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        #1 reset = 1'b1;
        #1;
        check_output("t5_async_active", 16'(active), 16'h0000);
        check_output("t5_async_data", 16'(data_out), 16'h0000);
        check_output("t5_async_valid", 16'(valid_out), 16'h0000);
        check_output("t5_async_strobe", 16'(byte_strobe), 16'h0000);
        @(negedge clk_32f);
        reset = 1'b0;
        bits_q.delete();
        repeat (3) send_byte(COM);
        check_output("t5_relock_wait", 16'(active), 16'h0000);
        send_byte(COM);
        check_output("t5_relock", 16'(active), 16'h0001);
        send_byte(8'h77);
        check_output("t5_77_data", 16'(data_out), 16'h0077);

`ifdef RX_BYTE_COUNT_EN
        // Ten data bytes with three idle COMs interleaved.
        apply_reset(2);
        repeat (4) send_byte(COM);
        for (int i = 0; i < 10; i++) begin
            send_byte(8'(8'h20 + i));
            if (i % 3 == 1) send_byte(COM);
        end
        check_output("t6_byte_count", rx_byte_count, 16'd10);
`endif

        // Random streams: junk bits, COM runs of random length, random data.
        for (int ep = 0; ep < 12; ep++) begin
            apply_reset(1 + int'($urandom_range(0, 2)));
            repeat ($urandom_range(0, 12)) send_bit(1'($urandom));
            for (int seg = 0; seg < 3; seg++) begin
                repeat ($urandom_range(1, 6)) send_byte(COM);
                repeat ($urandom_range(1, 4)) begin
                    rb = 8'($urandom);
                    if ($urandom_range(0, 3) == 0) rb = COM;
                    send_byte(rb);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
Per-lane receive deserializer; consumes the serial bit stream produced by one transmit lane's parallel-to-serial stage (MSB first, COM symbol 0xBC sent while idle).
- Finds byte alignment by hunting for COM, then confirms lock after a run of consecutive aligned COMs.
- Emits 8-bit symbols with a valid flag: COM = idle, not data.
- Two instances (lane 0, lane 1) feed the receive-side byte un-striping stage.

Parameters:
COM, 8'hBC, alignment/idle symbol.
COM_COUNT, 4, consecutive byte-aligned COMs required to declare lock (legal range 2..15).

Ports:
clk_32f  input  1  bit clock, one serial bit per rising edge
reset  input  1  asynchronous, active-high
data_in  input  1  serial lane bit, MSB of each byte first
data_out  output  8  last received byte in ACTIVE
valid_out  output  1  data_out is a data byte (not COM)
byte_strobe  output  1  one-cycle pulse at each byte boundary in ACTIVE
active  output  1  lane locked (state == ACTIVE)

Behaviour:
- One clock: clk_32f. reset asynchronous, active-high.
- While reset is high, all of the following are forced to 0:
  - data_out, valid_out, byte_strobe, active
  - shift register sr[7:0], bit_cnt[2:0], com_cnt
  - state = SEARCH
- Every edge: nxt = {sr[6:0], data_in}; sr <= nxt.
- FSM states: SEARCH, ALIGN, ACTIVE.
- SEARCH:
  - Bit-by-bit hunt.
  - If nxt == COM: bit_cnt <= 0, com_cnt <= 1, go ALIGN.
  - Otherwise stay in SEARCH.
- ALIGN and ACTIVE: bit_cnt increments every edge, wraps 7 -> 0. A byte boundary is the edge where bit_cnt == 7; nxt is the complete byte there.
- ALIGN, at a boundary:
  - nxt == COM and com_cnt+1 == COM_COUNT: go ACTIVE, active <= 1.
  - nxt == COM otherwise: com_cnt++.
  - nxt != COM: go SEARCH, com_cnt <= 0. The same nxt is not re-tested that edge; the hunt resumes on the next bit.
- ALIGN outputs: data_out, valid_out and byte_strobe stay 0.
- ACTIVE, at a boundary:
  - data_out <= nxt; valid_out <= (nxt != COM); byte_strobe <= 1.
  - data_out and valid_out hold for the 8 cycles until the next boundary.
  - byte_strobe is 0 on all other edges.
- ACTIVE is left only via reset. No lock-loss detection in this block.
- Latency: the LSB of a byte is sampled at edge N; data_out/valid_out/byte_strobe update on that same edge N (registered, visible after edge N).
- The first COM_COUNT COMs that achieve lock are never presented on data_out.
- Reset asserted mid-byte: state returns to SEARCH, and the partial byte is discarded.

Optional Feature:
Macro RX_BYTE_COUNT_EN.
- Defined:
  - Extra output port rx_byte_count [15:0].
  - Increments at each ACTIVE boundary where valid_out is set.
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
1. Reset held 5 cycles, data_in = 1 -> data_out = 8'h00; valid_out, byte_strobe, active = 0; after release with data_in = 0 for 40 cycles, state stays SEARCH and active = 0.
2. Send 3 junk bits 101, then 4 x 8'hBC, then 8'hA5, 8'h3C:
   - active rises on the edge sampling the LSB of the 4th COM.
   - byte_strobe pulses 8 cycles later with data_out = 8'hA5, valid_out = 1.
   - Next pulse: data_out = 8'h3C.
3. In ACTIVE, send 8'hBC, 8'h5A, 8'hBC -> data_out/valid_out sequence BC/0, 5A/1, BC/0; byte_strobe pulses exactly every 8 cycles.
4. Send 3 x 8'hBC, then 8'h00, then 4 x 8'hBC, then 8'h11:
   - Returns to SEARCH after the 8'h00; active stays 0.
   - Locks on the second COM run; data_out = 8'h11, valid_out = 1.
5. Reset pulsed for 1 cycle mid-byte in ACTIVE -> all outputs 0 immediately (async); 4 fresh COMs needed before active returns to 1.
6. (RX_BYTE_COUNT_EN) After lock, 10 data bytes interleaved with 3 COMs -> rx_byte_count = 10. Reset, then stream 65540 data bytes -> saturates at 16'hFFFF.
